qracc_output_scaler: RTL and testbench
======================================

Name: qracc_output_scaler

Overview:
- Post-MAC requantization stage, directly downstream of the QRAcc column accumulators.
- Takes one beat of numCols signed accumulator values and applies a per-column multiplier and a per-column right shift with round-half-up.
- Saturates each result to outputBits and hands the beat to the activation buffer write path over a valid/ready handshake.
- Per-column scale and shift registers are loaded through the output_scaler_scale_w_en / output_scaler_shift_w_en control strobes.

Parameters:
- numCols, 32, columns per beat (qracc_pkg::numCols).
- accumulatorBits, 16, signed accumulator width per column.
- outputBits, 16, signed output width per column.
- scaleBits, 16, unsigned per-column multiplier width.
- shiftBits, 5, per-column right-shift amount width (0..31).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset, asynchronous assert, active-low.
- acc_i  in  numCols*accumulatorBits  column accumulators; column c at [c*accumulatorBits +: accumulatorBits].
- acc_valid_i  in  1  acc_i valid.
- acc_ready_o  out  1  stage can accept a beat.
- out_data_o  out  numCols*outputBits  scaled outputs, same column packing.
- out_valid_o  out  1  out_data_o valid.
- out_ready_i  in  1  consumer accepts.
- scale_w_en_i  in  1  write cfg_data_i[scaleBits-1:0] to scale[cfg_addr_i].
- shift_w_en_i  in  1  write cfg_data_i[shiftBits-1:0] to shift[cfg_addr_i].
- cfg_addr_i  in  $clog2(numCols)  column index.
- cfg_data_i  in  32  config write data.
- busy_o  out  1  any pipeline stage holds a beat.

Behaviour:
- Reset (nrst low, asynchronous):
  - all scale registers = 1, all shift registers = 0;
  - both stage valid bits = 0, out_data_o = 0, out_valid_o = 0, busy_o = 0.
- Pipeline: two registered stages, S1 = multiply, S2 = round/shift/saturate. out_data_o/out_valid_o are S2 register outputs.
- Handshake:
  - beat accepted on the edge where acc_valid_i && acc_ready_o;
  - acc_ready_o = !s1_valid || s1_advance;
  - s1_advance = !s2_valid || out_ready_i.
- Latency and throughput: out_valid_o rises 2 cycles after acceptance. Throughput is 1 beat/cycle when out_ready_i is held high.
- Backpressure: while out_valid_o && !out_ready_i:
  - out_data_o is held stable;
  - S1 holds its beat;
  - acc_ready_o = 0 if S1 is full.
  - No beat is dropped or duplicated.
- S1 capture:
  - prod[c] = signed(acc[c]) * signed({1'b0, scale[c]}), width accumulatorBits+scaleBits+1;
  - shift[c] is captured alongside prod[c] in S1.
- S2 capture:
  - r = prod + (sh>0 ? 1<<(sh-1) : 0);
  - v = r >>> sh (arithmetic);
  - clamp v to [-2^(outputBits-1), 2^(outputBits-1)-1].
- Config write timing:
  - registers update on the edge after the strobe;
  - a beat uses the scale/shift values present at the edge it enters S1;
  - writes during busy are legal and do not affect beats already in S1/S2.
- Simultaneous scale_w_en_i and shift_w_en_i: both written, from the same cfg_data_i, to the same column.
- cfg_addr_i >= numCols: write ignored.
- busy_o = s1_valid | s2_valid.
- Reset mid-operation: all in-flight beats are discarded; config returns to default values.

Optional Feature:
- Macro: QRACC_OUTPUT_RELU_EN.
- Defined: after saturation, negative results are forced to 0, so the output range is [0, 2^(outputBits-1)-1]. This supports unsigned activations for the next layer.
- Undefined: signed saturated output as specified above.

Test Plan:
- Defaults: reset, acc[c] = c-16 for all c, out_ready_i = 1 → 2 cycles later out[c] = c-16 (scale 1, shift 0).
- Rounding: scale[3] = 3, shift[3] = 2; acc[3] = 5 → 4 (15+2 = 17, >>2); acc[3] = -5 → -4 (-15+2 = -13, >>>2); acc[3] = 6 → 5.
- Saturation: scale[0] = 65535, shift[0] = 0; acc[0] = 32767 → 32767; acc[0] = -32768 → -32768. With QRACC_OUTPUT_RELU_EN, the -32768 case gives 0.
- Backpressure: stream beats 1..4 (all columns = n) with out_ready_i low for 3 cycles after the first out_valid_o:
  - acc_ready_o drops once S1 fills;
  - outputs arrive in order 1, 2, 3, 4, each exactly once;
  - out_data_o is stable while stalled.
- Config during busy: beat A accepted with scale[5] = 2; scale[5] = 4 written the next cycle; beat B accepted after that; acc[5] = 10 for both → A gives 20, B gives 40.
- Mid-operation reset: nrst pulsed low with 2 beats in flight → out_valid_o = 0 and busy_o = 0 immediately; the next beat uses scale 1, shift 0.

Source files
------------

// File: rtl/qracc_output_scaler.sv
// qracc_output_scaler: post-MAC requantization stage.
// Each accumulator column is multiplied by an unsigned per-column scale,
// right-shifted by a per-column amount with round-half-up, saturated to
// outputBits, and handed downstream over a valid/ready handshake.
// Two pipeline stages: S1 = multiply, S2 = round/shift/saturate.
// Optional feature macro: QRACC_OUTPUT_RELU_EN (clamp negatives to 0).
module qracc_output_scaler #(
    parameter int numCols         = 32,
    parameter int accumulatorBits = 16,
    parameter int outputBits      = 16,
    parameter int scaleBits       = 16,
    parameter int shiftBits       = 5
) (
    input  logic                                 clk,
    input  logic                                 nrst,
    input  logic [numCols*accumulatorBits-1:0]   acc_i,
    input  logic                                 acc_valid_i,
    output logic                                 acc_ready_o,
    output logic [numCols*outputBits-1:0]        out_data_o,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    input  logic                                 scale_w_en_i,
    input  logic                                 shift_w_en_i,
    input  logic [$clog2(numCols)-1:0]           cfg_addr_i,
    input  logic [31:0]                          cfg_data_i,
    output logic                                 busy_o
);

    localparam int PROD_W = accumulatorBits + scaleBits + 1;
    localparam int RND_W  = PROD_W + 1;

    localparam logic signed [RND_W-1:0] OUT_MAX =
        {{(RND_W-outputBits+1){1'b0}}, {(outputBits-1){1'b1}}};
    localparam logic signed [RND_W-1:0] OUT_MIN = ~OUT_MAX;

    // Adds half an LSB of the shifted result, then shifts arithmetically.
    // One extra bit of headroom keeps the bias add from overflowing.
    function automatic logic signed [RND_W-1:0] round_shift(
        input logic signed [PROD_W-1:0] prod,
        input logic [shiftBits-1:0]     sh
    );
        logic signed [RND_W-1:0] bias;
        logic signed [RND_W-1:0] r;
        bias = '0;
        if (sh != '0) begin
            bias = {{(RND_W-1){1'b0}}, 1'b1} << (sh - 1'b1);
        end
        r = {prod[PROD_W-1], prod} + bias;
        return r >>> sh;
    endfunction

    // Clamps to the signed output range (and to zero for negatives when
    // the next layer expects unsigned activations).
    function automatic logic [outputBits-1:0] saturate(
        input logic signed [RND_W-1:0] v
    );
        logic [outputBits-1:0] res;
        if (v > OUT_MAX) begin
            res = OUT_MAX[outputBits-1:0];
        end else if (v < OUT_MIN) begin
            res = OUT_MIN[outputBits-1:0];
        end else begin
            res = v[outputBits-1:0];
        end
`ifdef QRACC_OUTPUT_RELU_EN
        if (res[outputBits-1]) begin
            res = '0;
        end
`endif
        return res;
    endfunction

    logic [scaleBits-1:0]           scale_q    [numCols];
    logic [shiftBits-1:0]           shift_q    [numCols];

    logic signed [PROD_W-1:0]       prod_d     [numCols];
    logic signed [PROD_W-1:0]       prod_p1_q  [numCols];
    logic [shiftBits-1:0]           shift_p1_q [numCols];
    logic                           vld_p1_q;

    logic [numCols*outputBits-1:0]  out_d;
    logic [numCols*outputBits-1:0]  out_data_p2_q;
    logic                           vld_p2_q;

    logic                           s1_advance;
    logic                           accept;
    logic                           cfg_addr_ok;
    logic                           unused_cfg_bits;

    assign s1_advance  = !vld_p2_q || out_ready_i;
    assign acc_ready_o = !vld_p1_q || s1_advance;
    assign accept      = acc_valid_i && acc_ready_o;
    assign busy_o      = vld_p1_q | vld_p2_q;
    assign out_valid_o = vld_p2_q;
    assign out_data_o  = out_data_p2_q;
    assign cfg_addr_ok = int'(cfg_addr_i) < numCols;

    assign unused_cfg_bits = ^cfg_data_i[31:scaleBits];

    genvar c;
    generate
        for (c = 0; c < numCols; c++) begin : g_col
            assign prod_d[c] =
                $signed({{(PROD_W-accumulatorBits){acc_i[c*accumulatorBits+accumulatorBits-1]}},
                         acc_i[c*accumulatorBits +: accumulatorBits]}) *
                $signed({{(PROD_W-scaleBits){1'b0}}, scale_q[c]});
            assign out_d[c*outputBits +: outputBits] =
                saturate(round_shift(prod_p1_q[c], shift_p1_q[c]));
        end
    endgenerate

    // Per-column scale/shift registers; both strobes may hit one column at once.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < numCols; i++) begin
                scale_q[i] <= scaleBits'(1);
                shift_q[i] <= '0;
            end
        end else if (cfg_addr_ok) begin
            if (scale_w_en_i) begin
                scale_q[cfg_addr_i] <= cfg_data_i[scaleBits-1:0];
            end
            if (shift_w_en_i) begin
                shift_q[cfg_addr_i] <= cfg_data_i[shiftBits-1:0];
            end
        end
    end

    // S1 data: product and the shift amount travel together, so later
    // config writes cannot touch a beat already in flight.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < numCols; i++) begin
                prod_p1_q[i]  <= prod_d[i];
                shift_p1_q[i] <= shift_q[i];
            end
        end
    end

    // Stage valids and the S2 output register; S2 holds while stalled.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vld_p1_q      <= 1'b0;
            vld_p2_q      <= 1'b0;
            out_data_p2_q <= '0;
        end else begin
            if (acc_ready_o) begin
                vld_p1_q <= acc_valid_i;
            end
            if (s1_advance) begin
                vld_p2_q <= vld_p1_q;
                if (vld_p1_q) begin
                    out_data_p2_q <= out_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_qracc_output_scaler.sv
// Testbench for qracc_output_scaler: scoreboard of expected beats built
// from a behavioural model of the configuration, plus per-scenario checks.
module tb_qracc_output_scaler;

    localparam int NC = 32;
    localparam int AB = 16;
    localparam int OB = 16;

    logic                 clk = 1'b0;
    logic                 nrst = 1'b0;
    logic [NC*AB-1:0]     acc_i = '0;
    logic                 acc_valid_i = 1'b0;
    logic                 acc_ready_o;
    logic [NC*OB-1:0]     out_data_o;
    logic                 out_valid_o;
    logic                 out_ready_i = 1'b1;
    logic                 scale_w_en_i = 1'b0;
    logic                 shift_w_en_i = 1'b0;
    logic [4:0]           cfg_addr_i = '0;
    logic [31:0]          cfg_data_i = '0;
    logic                 busy_o;

    int checks = 0;
    int errors = 0;
    int pops   = 0;

    int m_scale [NC];
    int m_shift [NC];
    logic [NC*OB-1:0] sb  [$];
    logic [NC*OB-1:0] obs [$];

    qracc_output_scaler dut (
        .clk          (clk),
        .nrst         (nrst),
        .acc_i        (acc_i),
        .acc_valid_i  (acc_valid_i),
        .acc_ready_o  (acc_ready_o),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .scale_w_en_i (scale_w_en_i),
        .shift_w_en_i (shift_w_en_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_data_i   (cfg_data_i),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [NC*OB-1:0] model(input logic [NC*AB-1:0] a);
        logic [NC*OB-1:0] res;
        longint p, r, v;
        for (int c = 0; c < NC; c++) begin
            p = longint'($signed(a[c*AB +: AB])) * longint'(m_scale[c]);
            r = p + ((m_shift[c] > 0) ? (longint'(1) << (m_shift[c] - 1)) : 0);
            v = r >>> m_shift[c];
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
`ifdef QRACC_OUTPUT_RELU_EN
            if (v < 0) v = 0;
`endif
            res[c*OB +: OB] = v[OB-1:0];
        end
        return res;
    endfunction

    function automatic logic [NC*AB-1:0] fill(input int val);
        logic [NC*AB-1:0] v;
        for (int c = 0; c < NC; c++) v[c*AB +: AB] = AB'(val);
        return v;
    endfunction

    // Scoreboard: pop/compare on each output transfer, push on each acceptance,
    // then mirror config writes (so a beat sees config from before the edge).
    always @(negedge clk or negedge nrst) begin
        if (!nrst) begin
            sb.delete();
            for (int c = 0; c < NC; c++) begin
                m_scale[c] = 1;
                m_shift[c] = 0;
            end
        end else begin
            if (out_valid_o && out_ready_i) begin
                checks++;
                pops++;
                obs.push_back(out_data_o);
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_underflow got %h expected no beat", out_data_o);
                end else begin
                    logic [NC*OB-1:0] exp_v;
                    exp_v = sb.pop_front();
                    if (out_data_o !== exp_v) begin
                        errors++;
                        $display("FAIL scoreboard_data got %h expected %h", out_data_o, exp_v);
                    end
                end
            end
            if (acc_valid_i && acc_ready_o) sb.push_back(model(acc_i));
            if (int'(cfg_addr_i) < NC) begin
                if (scale_w_en_i) m_scale[cfg_addr_i] = int'(cfg_data_i[15:0]);
                if (shift_w_en_i) m_shift[cfg_addr_i] = int'(cfg_data_i[4:0]);
            end
        end
    end

    task automatic write_cfg(input int addr, input logic [31:0] data,
                             input logic sc, input logic sh);
        cfg_addr_i   = 5'(addr);
        cfg_data_i   = data;
        scale_w_en_i = sc;
        shift_w_en_i = sh;
        @(posedge clk); #1;
        scale_w_en_i = 1'b0;
        shift_w_en_i = 1'b0;
    endtask

    task automatic send_beat(input logic [NC*AB-1:0] v);
        bit ok = 0;
        acc_valid_i = 1'b1;
        acc_i = v;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (acc_ready_o) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL send_timeout got ready=0 required ready=1");
        end
    endtask

    task automatic wait_drain;
        bit ok = 0;
        for (int k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !busy_o) begin ok = 1; break; end
            @(posedge clk); #1;
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL drain_timeout got pending=%0d required 0", sb.size());
        end
    endtask

    task automatic test_reset;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b required 0", out_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b required 0", busy_o); end
        checks++; if (out_data_o !== '0) begin errors++; $display("FAIL rst_out_data got %h required 0", out_data_o); end
        checks++; if (acc_ready_o !== 1'b1) begin errors++; $display("FAIL rst_acc_ready got %b required 1", acc_ready_o); end
        #2 nrst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_defaults;
        logic [NC*AB-1:0] v;
        logic [OB-1:0] e0;
        for (int c = 0; c < NC; c++) v[c*AB +: AB] = AB'(c - 16);
        obs.delete();
        acc_valid_i = 1'b1;
        acc_i = v;
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        checks++; if (out_valid_o !== 1'b0 || busy_o !== 1'b1) begin errors++; $display("FAIL latency_s1 got valid=%b busy=%b required valid=0 busy=1", out_valid_o, busy_o); end
        @(posedge clk); #1;
        checks++; if (out_valid_o !== 1'b1) begin errors++; $display("FAIL latency_s2 got valid=%b required 1", out_valid_o); end
        wait_drain();
`ifdef QRACC_OUTPUT_RELU_EN
        e0 = 16'h0000;
`else
        e0 = 16'hFFF0;
`endif
        checks++;
        if (obs.size() != 1) begin errors++; $display("FAIL defaults_count got %0d required 1", obs.size()); end
        else if (obs[0][0 +: OB] !== e0 || obs[0][31*OB +: OB] !== 16'd15) begin
            errors++; $display("FAIL defaults_cols got %h/%h required %h/000f", obs[0][0 +: OB], obs[0][31*OB +: OB], e0);
        end
    endtask

    task automatic test_rounding;
        logic [NC*AB-1:0] v;
        logic [OB-1:0] en;
        write_cfg(3, 32'd3, 1'b1, 1'b0);
        write_cfg(3, 32'd2, 1'b0, 1'b1);
        obs.delete();
        v = fill(0); v[3*AB +: AB] = 16'd5;       send_beat(v);
        v = fill(0); v[3*AB +: AB] = 16'hFFFB;    send_beat(v);
        v = fill(0); v[3*AB +: AB] = 16'd6;       send_beat(v);
        wait_drain();
`ifdef QRACC_OUTPUT_RELU_EN
        en = 16'h0000;
`else
        en = 16'hFFFC;
`endif
        checks++;
        if (obs.size() != 3) begin errors++; $display("FAIL round_count got %0d required 3", obs.size()); end
        else if (obs[0][3*OB +: OB] !== 16'd4 || obs[1][3*OB +: OB] !== en || obs[2][3*OB +: OB] !== 16'd5) begin
            errors++; $display("FAIL round_vals got %h %h %h required 0004 %h 0005",
                obs[0][3*OB +: OB], obs[1][3*OB +: OB], obs[2][3*OB +: OB], en);
        end
    endtask

    task automatic test_saturation;
        logic [NC*AB-1:0] v;
        logic [OB-1:0] en;
        write_cfg(0, 32'h0000_FFFF, 1'b1, 1'b0);
        write_cfg(9, 32'h0000_0022, 1'b1, 1'b1);
        obs.delete();
        v = fill(0); v[0 +: AB] = 16'h7FFF; v[9*AB +: AB] = 16'd10; send_beat(v);
        v = fill(0); v[0 +: AB] = 16'h8000; v[9*AB +: AB] = 16'd10; send_beat(v);
        wait_drain();
`ifdef QRACC_OUTPUT_RELU_EN
        en = 16'h0000;
`else
        en = 16'h8000;
`endif
        checks++;
        if (obs.size() != 2) begin errors++; $display("FAIL sat_count got %0d required 2", obs.size()); end
        else begin
            if (obs[0][0 +: OB] !== 16'h7FFF || obs[1][0 +: OB] !== en) begin
                errors++; $display("FAIL sat_vals got %h %h required 7fff %h", obs[0][0 +: OB], obs[1][0 +: OB], en);
            end
            checks++;
            if (obs[0][9*OB +: OB] !== 16'd85) begin
                errors++; $display("FAIL dual_write got %h required 0055", obs[0][9*OB +: OB]);
            end
        end
    endtask

    task automatic test_backpressure;
        int n = 1;
        int stall = 0;
        bit got_valid = 0;
        bit seen_drop = 0;
        bit stable_ok = 1;
        bit accepted;
        int pops0 = pops;
        logic [NC*OB-1:0] held = '0;
        out_ready_i = 1'b1;
        acc_valid_i = 1'b1;
        acc_i = fill(1);
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            if (acc_valid_i && !acc_ready_o) seen_drop = 1;
            accepted = acc_valid_i && acc_ready_o;
            @(posedge clk); #1;
            if (accepted) begin
                n++;
                if (n > 4) acc_valid_i = 1'b0;
                else acc_i = fill(n);
            end
            if (!got_valid && out_valid_o) begin
                got_valid = 1;
                stall = 3;
                held = out_data_o;
                out_ready_i = 1'b0;
            end else if (stall > 0) begin
                if (out_data_o !== held || out_valid_o !== 1'b1) stable_ok = 0;
                stall--;
                if (stall == 0) out_ready_i = 1'b1;
            end
        end
        wait_drain();
        checks++; if (!seen_drop) begin errors++; $display("FAIL bp_ready_drop got no drop required drop"); end
        checks++; if (!stable_ok) begin errors++; $display("FAIL bp_stable got changing data required held %h", held); end
        checks++; if (pops - pops0 != 4) begin errors++; $display("FAIL bp_count got %0d required 4", pops - pops0); end
    endtask

    task automatic test_cfg_busy;
        write_cfg(5, 32'd2, 1'b1, 1'b0);
        obs.delete();
        acc_valid_i = 1'b1;
        acc_i = fill(10);
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        cfg_addr_i = 5'd5;
        cfg_data_i = 32'd4;
        scale_w_en_i = 1'b1;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL cfg_busy_flag got %b required 1", busy_o); end
        @(posedge clk); #1;
        scale_w_en_i = 1'b0;
        send_beat(fill(10));
        wait_drain();
        checks++;
        if (obs.size() != 2) begin errors++; $display("FAIL cfg_count got %0d required 2", obs.size()); end
        else if (obs[0][5*OB +: OB] !== 16'd20 || obs[1][5*OB +: OB] !== 16'd40) begin
            errors++; $display("FAIL cfg_vals got %0d %0d required 20 40", obs[0][5*OB +: OB], obs[1][5*OB +: OB]);
        end
    endtask

    task automatic test_reset_mid;
        write_cfg(1, 32'd5, 1'b1, 1'b1);
        out_ready_i = 1'b0;
        acc_valid_i = 1'b1;
        acc_i = fill(3);
        @(posedge clk); #1;
        acc_i = fill(4);
        @(posedge clk); #1;
        acc_valid_i = 1'b0;
        #1 nrst = 1'b0;
        #1;
        checks++; if (out_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b required 0", out_valid_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b required 0", busy_o); end
        #4 nrst = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        obs.delete();
        send_beat(fill(7));
        wait_drain();
        checks++;
        if (obs.size() != 1) begin errors++; $display("FAIL midrst_count got %0d required 1", obs.size()); end
        else if (obs[0][1*OB +: OB] !== 16'd7 || obs[0][0 +: OB] !== 16'd7) begin
            errors++; $display("FAIL midrst_cfg got %h %h required 0007 0007", obs[0][1*OB +: OB], obs[0][0 +: OB]);
        end
    endtask

    initial begin
        test_reset();
        test_defaults();
        test_rounding();
        test_saturation();
        test_backpressure();
        test_cfg_busy();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
